logic_gate_unit: RTL and testbench

LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

---
 rtl/logic_gate_unit_if.sv | 44 ++++
 rtl/logic_gate_unit.sv | 211 +++++++++++++++++++++
 tb/tb_logic_gate_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_gate_unit_if.sv
// ----------------------------------------------------------------------------
// logic_gate_unit_if
// Request/response bundle for logic_gate_unit.
//   in_valid/in_ready : request handshake carrying op, a, b
//   out_valid/out_ready : result handshake carrying y
// master : requester side (drives the request, consumes the result)
// slave  : the unit itself
// ----------------------------------------------------------------------------
interface logic_gate_unit_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;

   modport master (
      output in_valid,
      output op,
      output a,
      output b,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  y
   );

   modport slave (
      input  in_valid,
      input  op,
      input  a,
      input  b,
      input  out_ready,
      output in_ready,
      output out_valid,
      output y
   );

endinterface : logic_gate_unit_if

// File: rtl/logic_gate_unit.sv
// ----------------------------------------------------------------------------
// logic_gate_unit
// Registered bitwise gate unit (AND/OR/XOR/NAND/NOR/XNOR/NOT_A/PASS_A) with a
// single-entry output register, a wrapping accept counter and an optional
// 32-vector self-sweep that counts the 1 bits it produces.
//
// Ports
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   bus         : logic_gate_unit_if.slave (request op/a/b, result y)
//   xfer_count  : accepted requests, modulo 2^16
//   sweep_start : one-cycle pulse to launch the self-sweep
//   sweep_busy  : sweep running
//   sweep_done  : one-cycle pulse when the sweep finishes
//   sweep_ones  : popcount total of the last sweep
//
// Build option
//   LOGIC_GATE_UNIT_SWEEP_EN : when defined the self-sweep is compiled in;
//   otherwise sweep_start is ignored and the sweep outputs are tied to 0.
// ----------------------------------------------------------------------------
module logic_gate_unit #(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   logic_gate_unit_if.slave bus,
   output logic [CNT_W-1:0] xfer_count,
   input  logic             sweep_start,
   output logic             sweep_busy,
   output logic             sweep_done,
   output logic [CNT_W-1:0] sweep_ones
);

   localparam logic [2:0] OP_AND   = 3'd0;
   localparam logic [2:0] OP_OR    = 3'd1;
   localparam logic [2:0] OP_XOR   = 3'd2;
   localparam logic [2:0] OP_NAND  = 3'd3;
   localparam logic [2:0] OP_NOR   = 3'd4;
   localparam logic [2:0] OP_XNOR  = 3'd5;
   localparam logic [2:0] OP_NOT_A = 3'd6;

   // Bitwise gate shared by the request path and the sweep
   function automatic logic [WIDTH-1:0] gate_fn(
      input logic [2:0]       sel,
      input logic [WIDTH-1:0] opa,
      input logic [WIDTH-1:0] opb
   );
      logic [WIDTH-1:0] r;
      case (sel)
         OP_AND:   r = opa & opb;
         OP_OR:    r = opa | opb;
         OP_XOR:   r = opa ^ opb;
         OP_NAND:  r = ~(opa & opb);
         OP_NOR:   r = ~(opa | opb);
         OP_XNOR:  r = ~(opa ^ opb);
         OP_NOT_A: r = ~opa;
         default:  r = opa;            // PASS_A
      endcase
      return r;
   endfunction

   // Number of set bits in a result word
   function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   // ------------------------------------------------------------------------
   // Self-sweep
   // ------------------------------------------------------------------------
   logic sweep_gate_c;   // high when the sweep allows a request this cycle

`ifdef LOGIC_GATE_UNIT_SWEEP_EN

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } sweep_state_e;

   localparam logic [4:0] K_LAST = 5'd31;

   sweep_state_e     state_q, state_d;
   logic [4:0]       k_q, k_d;
   logic [CNT_W-1:0] ones_q, ones_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] sweep_res_c;

   // Vector k: op = k[4:2], a and b replicate k[1] and k[0]
   assign sweep_res_c = gate_fn(k_q[4:2], {WIDTH{k_q[1]}}, {WIDTH{k_q[0]}});

   // sweep_start takes priority over a same-cycle request
   assign sweep_gate_c = (state_q == S_IDLE) && !sweep_start;

   // Sweep state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         ones_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         ones_q  <= ones_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Sweep next-state and accumulation
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      ones_d  = ones_q;
      case (state_q)
         S_IDLE: begin
            if (sweep_start) begin
               state_d = S_RUN;
               k_d     = '0;
               ones_d  = '0;
            end
         end
         S_RUN: begin
            ones_d = ones_q + popcount(sweep_res_c);
            k_d    = k_q + 5'd1;
            if (k_q == K_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Status flags are registered copies of the next state
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   assign sweep_busy = busy_q;
   assign sweep_done = done_q;
   assign sweep_ones = ones_q;

`else

   logic unused_sweep_start;

   assign unused_sweep_start = sweep_start;
   assign sweep_gate_c       = 1'b1;
   assign sweep_busy         = 1'b0;
   assign sweep_done         = 1'b0;
   assign sweep_ones         = '0;

`endif

   // ------------------------------------------------------------------------
   // Request path: single-entry output register plus accept counter
   // ------------------------------------------------------------------------
   logic             in_ready_c;
   logic             accept_c;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [CNT_W-1:0] xfer_q, xfer_d;

   // Ready when the slot is empty or drains this cycle; blocked in reset
   assign in_ready_c = !rst && sweep_gate_c && (!out_valid_q || bus.out_ready);
   assign accept_c   = bus.in_valid && in_ready_c;

   // Output register and counter next state
   always_comb begin
      out_valid_d = out_valid_q;
      y_d         = y_q;
      xfer_d      = xfer_q;
      if (accept_c) begin
         out_valid_d = 1'b1;
         y_d         = gate_fn(bus.op, bus.a, bus.b);
         xfer_d      = xfer_q + CNT_W'(1);
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output register and counter state
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
         xfer_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         xfer_q      <= xfer_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign xfer_count    = xfer_q;

endmodule : logic_gate_unit

// File: tb/tb_logic_gate_unit.sv
// ----------------------------------------------------------------------------
// tb_logic_gate_unit
// Directed self-checking bench for logic_gate_unit (WIDTH = 8). Sweep
// scenarios are selected by LOGIC_GATE_UNIT_SWEEP_EN to match the RTL build.
// ----------------------------------------------------------------------------
module tb_logic_gate_unit;

   localparam int unsigned WIDTH = 8;

   logic        clk;
   logic        rst;
   logic        sweep_start;
   logic        sweep_busy;
   logic        sweep_done;
   logic [15:0] sweep_ones;
   logic [15:0] xfer_count;

   int unsigned n_tests;
   int unsigned n_fail;

   logic_gate_unit_if #(.WIDTH(WIDTH)) bus ();

   logic_gate_unit #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .xfer_count  (xfer_count),
      .sweep_start (sweep_start),
      .sweep_busy  (sweep_busy),
      .sweep_done  (sweep_done),
      .sweep_ones  (sweep_ones)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic v, input logic [2:0] o,
                            input logic [7:0] av, input logic [7:0] bv);
      bus.in_valid = v;
      bus.op       = o;
      bus.a        = av;
      bus.b        = bv;
   endtask

   // Hand truth tables, bit index {a,b} with a,b in {0,1}
   logic [3:0] tt [8];
   initial begin
      tt[0] = 4'b1000;  // AND
      tt[1] = 4'b1110;  // OR
      tt[2] = 4'b0110;  // XOR
      tt[3] = 4'b0111;  // NAND
      tt[4] = 4'b0001;  // NOR
      tt[5] = 4'b1001;  // XNOR
      tt[6] = 4'b0011;  // NOT_A
      tt[7] = 4'b1100;  // PASS_A
   end

   initial begin
      logic [3:0] row;
      logic [7:0] av, bv, exp_y;
      int unsigned busy_cycles;
      logic        saw_done;

      n_tests       = 0;
      n_fail        = 0;
      rst           = 1'b1;
      sweep_start   = 1'b0;
      bus.out_ready = 1'b1;
      drive_req(1'b0, 3'd0, 8'h00, 8'h00);

      // Reset state
      tick();
      tick();
      check_eq("rst_in_ready", 64'(bus.in_ready), 64'h0);
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'h0);
      check_eq("rst_y", 64'(bus.y), 64'h0);
      check_eq("rst_xfer", 64'(xfer_count), 64'h0);
      check_eq("rst_busy", 64'(sweep_busy), 64'h0);
      check_eq("rst_done", 64'(sweep_done), 64'h0);
      check_eq("rst_ones", 64'(sweep_ones), 64'h0);
      rst = 1'b0;

      // AND then NAND on F0/CC
      drive_req(1'b1, 3'd0, 8'hF0, 8'hCC);
      #1;
      check_eq("idle_in_ready", 64'(bus.in_ready), 64'h1);
      tick();
      check_eq("and_valid", 64'(bus.out_valid), 64'h1);
      check_eq("and_y", 64'(bus.y), 64'hC0);
      drive_req(1'b1, 3'd3, 8'hF0, 8'hCC);
      tick();
      check_eq("nand_y", 64'(bus.y), 64'h3F);
      check_eq("nand_xfer", 64'(xfer_count), 64'h2);
      drive_req(1'b0, 3'd0, 8'h00, 8'h00);
      tick();
      check_eq("drain_valid", 64'(bus.out_valid), 64'h0);
      check_eq("drain_y_hold", 64'(bus.y), 64'h3F);

      // All ops over {00,FF} x {00,FF}, back to back
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int op_i = 0; op_i < 8; op_i++) begin
         for (int ab = 0; ab < 4; ab++) begin
            av    = (ab >= 2) ? 8'hFF : 8'h00;
            bv    = (ab % 2 == 1) ? 8'hFF : 8'h00;
            row   = tt[op_i];
            exp_y = row[ab] ? 8'hFF : 8'h00;
            drive_req(1'b1, 3'(op_i), av, bv);
            tick();
            check_eq($sformatf("tt_op%0d_ab%0d", op_i, ab), 64'(bus.y), 64'(exp_y));
            check_eq($sformatf("tt_valid%0d_%0d", op_i, ab), 64'(bus.out_valid), 64'h1);
         end
      end
      check_eq("tt_xfer", 64'(xfer_count), 64'd32);

      // Backpressure: stall three cycles, then drain and accept together
      drive_req(1'b1, 3'd2, 8'hA5, 8'h0F);
      tick();
      check_eq("xor_y", 64'(bus.y), 64'hAA);
      drive_req(1'b1, 3'd0, 8'hFF, 8'hFF);
      bus.out_ready = 1'b0;
      #1;
      check_eq("stall_in_ready", 64'(bus.in_ready), 64'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("stall_y%0d", i), 64'(bus.y), 64'hAA);
         check_eq($sformatf("stall_valid%0d", i), 64'(bus.out_valid), 64'h1);
         check_eq($sformatf("stall_rdy%0d", i), 64'(bus.in_ready), 64'h0);
      end
      bus.out_ready = 1'b1;
      #1;
      check_eq("release_in_ready", 64'(bus.in_ready), 64'h1);
      tick();
      check_eq("release_y", 64'(bus.y), 64'hFF);
      check_eq("release_valid", 64'(bus.out_valid), 64'h1);
      check_eq("release_xfer", 64'(xfer_count), 64'd34);
      drive_req(1'b0, 3'd0, 8'h00, 8'h00);
      tick();
      check_eq("release_empty", 64'(bus.out_valid), 64'h0);

`ifdef LOGIC_GATE_UNIT_SWEEP_EN
      // Sweep with a result parked in the output register
      drive_req(1'b1, 3'd1, 8'h12, 8'h30);
      tick();
      drive_req(1'b0, 3'd0, 8'h00, 8'h00);
      bus.out_ready = 1'b0;
      tick();
      check_eq("park_y", 64'(bus.y), 64'h32);
      sweep_start = 1'b1;
      drive_req(1'b1, 3'd7, 8'h55, 8'h00);
      #1;
      check_eq("start_in_ready", 64'(bus.in_ready), 64'h0);
      tick();
      sweep_start = 1'b0;
      drive_req(1'b0, 3'd0, 8'h00, 8'h00);
      check_eq("start_no_accept", 64'(xfer_count), 64'd35);
      busy_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (!sweep_busy) break;
         busy_cycles++;
         tick();
      end
      check_eq("sweep_busy_len", 64'(busy_cycles), 64'd32);
      check_eq("sweep_done_pulse", 64'(sweep_done), 64'h1);
      check_eq("sweep_ones", 64'(sweep_ones), 64'd128);
      check_eq("sweep_keep_y", 64'(bus.y), 64'h32);
      check_eq("sweep_keep_valid", 64'(bus.out_valid), 64'h1);
      tick();
      check_eq("sweep_done_clear", 64'(sweep_done), 64'h0);
      check_eq("sweep_ones_hold", 64'(sweep_ones), 64'd128);
      bus.out_ready = 1'b1;
      tick();
      check_eq("sweep_drain", 64'(bus.out_valid), 64'h0);

      // Reset at sweep cycle 10 aborts without a done pulse
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      repeat (9) tick();
      check_eq("abort_busy_pre", 64'(sweep_busy), 64'h1);
      rst = 1'b1;
      tick();
      check_eq("abort_busy", 64'(sweep_busy), 64'h0);
      check_eq("abort_done", 64'(sweep_done), 64'h0);
      check_eq("abort_ones", 64'(sweep_ones), 64'h0);
      check_eq("abort_xfer", 64'(xfer_count), 64'h0);
      check_eq("abort_y", 64'(bus.y), 64'h0);
      rst = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (sweep_done) saw_done = 1'b1;
      end
      check_eq("abort_no_done", 64'(saw_done), 64'h0);
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (!sweep_busy) break;
         busy_cycles++;
         tick();
      end
      check_eq("resweep_len", 64'(busy_cycles), 64'd32);
      check_eq("resweep_ones", 64'(sweep_ones), 64'd128);
      tick();
`else
      // Without the sweep, sweep_start has no effect on a request
      sweep_start = 1'b1;
      drive_req(1'b1, 3'd6, 8'h0F, 8'h00);
      #1;
      check_eq("nosweep_in_ready", 64'(bus.in_ready), 64'h1);
      tick();
      sweep_start = 1'b0;
      drive_req(1'b0, 3'd0, 8'h00, 8'h00);
      check_eq("nosweep_y", 64'(bus.y), 64'hF0);
      check_eq("nosweep_busy", 64'(sweep_busy), 64'h0);
      check_eq("nosweep_done", 64'(sweep_done), 64'h0);
      check_eq("nosweep_ones", 64'(sweep_ones), 64'h0);
      tick();
      check_eq("nosweep_busy2", 64'(sweep_busy), 64'h0);
`endif

      // Counter wrap: 65535 accepts, then one more
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive_req(1'b1, 3'd7, 8'h5A, 8'h00);
      repeat (65535) @(posedge clk);
      #1;
      check_eq("xfer_ffff", 64'(xfer_count), 64'hFFFF);
      tick();
      check_eq("xfer_wrap", 64'(xfer_count), 64'h0000);
      check_eq("wrap_y", 64'(bus.y), 64'h5A);
      drive_req(1'b0, 3'd0, 8'h00, 8'h00);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_logic_gate_unit
